// File: rtl/top_rx_control_unit.sv
// top_rx_control_unit: assembles UART bytes into 16-bit samples, writes the FFT input RAM, starts the FFT and interlocks until results are sent
module top_rx_control_unit #(
  parameter int SAMPLES        = 32,
  parameter int ADDR_W         = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_RX_done,
  input  logic [7:0]        i_RX_byte,
  input  logic              i_FFT32_cycle_done,
  input  logic              i_full_TX_state,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_data,
  output logic              o_receive_state,
  output logic              o_FFT_start,
  output logic              o_frame_error,
  output logic              o_overrun
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, RECEIVE, START, WAIT_FFT, WAIT_TX} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [7:0]        low_q, low_d;
  logic [15:0]       data_q, data_d;
  logic              phase_q, phase_d, we_q, we_d, ferr_q, ferr_d, ovr_q, ovr_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    low_d   = low_q;
    data_d  = data_q;
    phase_d = phase_q;
    we_d    = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: if (i_RX_done) begin
        low_d   = i_RX_byte;
        idx_d   = '0;
        phase_d = 1'b1;
        cnt_d   = '0;
        state_d = RECEIVE;
      end
      RECEIVE: if (i_RX_done) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
        if (!phase_q) low_d = i_RX_byte;
        else begin
          we_d   = 1'b1;
          addr_d = idx_q;
          data_d = {i_RX_byte, low_q};
          idx_d  = idx_q + 1'b1;
          if (idx_q == ADDR_W'(SAMPLES - 1)) state_d = START;
        end
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        ferr_d  = 1'b1;
        phase_d = 1'b0;
        state_d = IDLE;
      end else cnt_d = cnt_q + 1'b1;
      START: begin
        ovr_d   = i_RX_done;
        state_d = WAIT_FFT;
      end
      WAIT_FFT: begin
        ovr_d   = i_RX_done;
        state_d = i_FFT32_cycle_done ? WAIT_TX : WAIT_FFT;
      end
      WAIT_TX: begin
        ovr_d   = i_RX_done;
        state_d = i_full_TX_state ? WAIT_TX : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      low_q   <= '0;
      data_q  <= '0;
      phase_q <= 1'b0;
      we_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      low_q   <= low_d;
      data_q  <= data_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign o_ram_we        = we_q;
  assign o_ram_addr      = addr_q;
  assign o_ram_data      = data_q;
  assign o_receive_state = (state_q == RECEIVE) || (state_q == START);
  assign o_FFT_start     = state_q == START;
  assign o_frame_error   = ferr_q;
  assign o_overrun       = ovr_q;
endmodule
